// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for the phase-reversing TDC delay-line array:
// preset, launch, settle, capture, phase-reverse, then average and hand off a result.
module tdc_meas_ctrl #(
   parameter int N_STAGES   = 32,
   parameter int CW         = 6,
   parameter int PRESET_CYC = 4,
   parameter int SETTLE_CYC = 8,
   parameter int AVG_LOG2   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                pr_en,
   input  logic [N_STAGES-1:0] therm_in,
   output logic                pstb,
   output logic                launch,
   output logic                phase_rev_clk,
   output logic [CW-1:0]       result,
   output logic                result_valid,
   input  logic                result_ready,
   output logic                bubble_err,
   output logic                busy
);

   localparam int CYC_MAX = (PRESET_CYC > SETTLE_CYC) ? PRESET_CYC : SETTLE_CYC;
   localparam int TW      = $clog2(CYC_MAX + 1);
   localparam int MW      = AVG_LOG2 + 1;
   localparam int AW      = CW + AVG_LOG2;

   localparam logic [TW-1:0] PRESET_LAST = TW'(PRESET_CYC - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [MW-1:0] MEAS_LAST   = MW'((1 << AVG_LOG2) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PRESET, S_LAUNCH, S_SETTLE, S_CAPTURE, S_PHREV, S_ACCUM, S_DONE
   } state_t;

   state_t        state_reg, state_next;
   logic [TW-1:0] cyc_reg;
   logic [MW-1:0] meas_reg;
   logic [AW-1:0] acc_reg;
   logic [AW-1:0] acc_sum;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_comb;
   logic [CW-1:0] result_reg;
   logic          pol_reg;
   logic          bubble_reg;
   logic          pstb_reg;
   logic          launch_reg;
   logic          prc_reg;
   logic          valid_reg;
   logic          busy_reg;

   logic [N_STAGES-1:0] code;
   logic [N_STAGES-2:0] bub_vec;
   logic                bubble_comb;

   // Captured levels flip meaning after every phase reversal; pol restores a 1-means-passed code.
   assign code = therm_in ^ {N_STAGES{~pol_reg}};

   generate
      for (genvar gi = 1; gi < N_STAGES; gi++) begin : g_bubble
         assign bub_vec[gi-1] = code[gi] & ~code[gi-1];
      end
   endgenerate

   assign bubble_comb = |bub_vec;

   always_comb begin
      count_comb = '0;
      for (int i = 0; i < N_STAGES; i++) begin
         count_comb = count_comb + CW'(code[i]);
      end
   end

   assign acc_sum = acc_reg + AW'(count_reg);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:    if (start) state_next = S_PRESET;
         S_PRESET:  if (cyc_reg == PRESET_LAST) state_next = S_LAUNCH;
         S_LAUNCH:  state_next = S_SETTLE;
         S_SETTLE:  if (cyc_reg == SETTLE_LAST) state_next = S_CAPTURE;
         S_CAPTURE: state_next = S_PHREV;
         S_PHREV:   state_next = S_ACCUM;
         S_ACCUM:   state_next = (meas_reg == MEAS_LAST) ? S_DONE : S_LAUNCH;
         S_DONE:    if (result_ready) state_next = S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         cyc_reg    <= '0;
         meas_reg   <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
         result_reg <= '0;
         pol_reg    <= 1'b1;
         bubble_reg <= 1'b0;
         pstb_reg   <= 1'b1;
         launch_reg <= 1'b0;
         prc_reg    <= 1'b0;
         valid_reg  <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pstb_reg   <= (state_next != S_PRESET);
         launch_reg <= (state_next == S_LAUNCH);
         prc_reg    <= (state_next == S_PHREV) && pr_en;
         valid_reg  <= (state_next == S_DONE);
         busy_reg   <= (state_next != S_IDLE);

         if ((state_next == state_reg) && ((state_reg == S_PRESET) || (state_reg == S_SETTLE)))
            cyc_reg <= cyc_reg + TW'(1);
         else
            cyc_reg <= '0;

         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  acc_reg    <= '0;
                  meas_reg   <= '0;
                  bubble_reg <= 1'b0;
               end
            end
            S_PRESET: pol_reg <= 1'b1;
            S_CAPTURE: begin
               count_reg <= count_comb;
               if (bubble_comb) bubble_reg <= 1'b1;
            end
            // pol flips on the same edge where phase_rev_clk falls
            S_PHREV: if (prc_reg) pol_reg <= ~pol_reg;
            S_ACCUM: begin
               acc_reg  <= acc_sum;
               meas_reg <= meas_reg + MW'(1);
               if (meas_reg == MEAS_LAST) result_reg <= CW'(acc_sum >> AVG_LOG2);
            end
            default: ;
         endcase
      end
   end

   assign pstb          = pstb_reg;
   assign launch        = launch_reg;
   assign phase_rev_clk = prc_reg;
   assign result        = result_reg;
   assign result_valid  = valid_reg;
   assign bubble_err    = bubble_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Bench for tdc_meas_ctrl: two instances (no averaging and 4-way averaging), each checked
// every cycle against a timeline model, plus directed literal expectations.
module tb_tdc_meas_ctrl;

   localparam int N  = 32;
   localparam int CW = 6;
   localparam int P  = 4;
   localparam int S  = 8;
   localparam int M  = S + 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_v   [2];
   logic          start_v [2];
   logic          pr_en_v [2];
   logic          ready_v [2];
   logic [N-1:0]  therm_v [2];
   wire           pstb_w   [2];
   wire           launch_w [2];
   wire           prc_w    [2];
   wire           valid_w  [2];
   wire           bubble_w [2];
   wire           busy_w   [2];
   wire [CW-1:0]  result_w [2];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         localparam int AVG = (gi == 0) ? 0 : 2;
         localparam int NM  = 1 << AVG;

         tdc_meas_ctrl #(
            .N_STAGES(N), .CW(CW), .PRESET_CYC(P), .SETTLE_CYC(S), .AVG_LOG2(AVG)
         ) dut (
            .clk(clk), .rst(rst_v[gi]), .start(start_v[gi]), .pr_en(pr_en_v[gi]),
            .therm_in(therm_v[gi]), .pstb(pstb_w[gi]), .launch(launch_w[gi]),
            .phase_rev_clk(prc_w[gi]), .result(result_w[gi]), .result_valid(valid_w[gi]),
            .result_ready(ready_v[gi]), .bubble_err(bubble_w[gi]), .busy(busy_w[gi])
         );

         // Model: 'off' is the cycle index since the accepted start; phases follow by arithmetic.
         bit         seen = 0, active = 0, pol = 1, bub = 0, phr = 0;
         bit         e_pstb = 1, e_launch = 0, e_prc = 0, e_valid = 0, e_busy = 0;
         int         off = 0, acc = 0, e_result = 0, j, r;
         logic [N-1:0] code;

         always @(posedge clk) begin
            if (rst_v[gi]) begin
               seen = 1; active = 0; off = 0; pol = 1; acc = 0; bub = 0; phr = 0; e_result = 0;
            end else if (!active) begin
               if (start_v[gi]) begin
                  active = 1; off = 1; acc = 0; bub = 0; pol = 1;
               end
            end else begin
               j = off - P - 1;
               if (off > P && j < NM * M) begin
                  r = j % M;
                  if (r == S + 1) begin
                     code = therm_v[gi] ^ (pol ? {N{1'b0}} : {N{1'b1}});
                     acc += $countones(code);
                     for (int i = 1; i < N; i++) if (code[i] && !code[i-1]) bub = 1;
                     phr = pr_en_v[gi];
                  end
                  if (r == S + 2 && phr) pol = ~pol;
               end
               if (off > P && j >= NM * M && ready_v[gi]) begin
                  active = 0;
                  $display("dut%0d result=%0d bubble_err=%0d", gi, e_result, bub);
               end
               off++;
            end
            e_pstb = 1; e_launch = 0; e_prc = 0; e_valid = 0; e_busy = 0;
            if (active) begin
               e_busy = 1;
               e_pstb = !(off >= 1 && off <= P);
               if (off > P) begin
                  j = off - P - 1;
                  if (j >= NM * M) begin
                     e_valid = 1;
                     if (j == NM * M) e_result = (acc >> AVG) & ((1 << CW) - 1);
                  end else begin
                     r = j % M;
                     e_launch = (r == 0);
                     e_prc = (r == S + 2) && phr;
                  end
               end
            end
         end

         always @(negedge clk) begin
            if (seen) begin
               chk($sformatf("d%0d_pstb", gi),   32'(pstb_w[gi]),   32'(e_pstb));
               chk($sformatf("d%0d_launch", gi), 32'(launch_w[gi]), 32'(e_launch));
               chk($sformatf("d%0d_prclk", gi),  32'(prc_w[gi]),    32'(e_prc));
               chk($sformatf("d%0d_valid", gi),  32'(valid_w[gi]),  32'(e_valid));
               chk($sformatf("d%0d_busy", gi),   32'(busy_w[gi]),   32'(e_busy));
               chk($sformatf("d%0d_bubble", gi), 32'(bubble_w[gi]), 32'(bub));
               chk($sformatf("d%0d_result", gi), 32'(result_w[gi]), e_result);
            end
         end
      end
   endgenerate

   task automatic pulse_start(input int d);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   task automatic wait_valid(input int d, output int n);
      n = 0;
      while (valid_w[d] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("valid_timeout", 32'(n), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, low, nv, nl, npr;
      logic [N-1:0] tbl [4];
      tbl[0] = 32'h0000_00FF;
      tbl[1] = ~32'h0000_FFFF;
      tbl[2] = 32'h0000_0000;
      tbl[3] = 32'hFFFF_FFFF;

      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; start_v[d] = 1'b0; pr_en_v[d] = 1'b0;
         ready_v[d] = 1'b0; therm_v[d] = '0;
      end
      repeat (3) @(negedge clk);
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("reset_pstb",   32'(pstb_w[d]),   32'd1);
         chk("reset_busy",   32'(busy_w[d]),   32'd0);
         chk("reset_valid",  32'(valid_w[d]),  32'd0);
         chk("reset_result", 32'(result_w[d]), 32'd0);
      end

      // Single measurement, latency and preset width, then backpressure in DONE.
      therm_v[0] = 32'h0000_00FF;
      pulse_start(0);
      n = 1; low = 0;
      while (valid_w[0] !== 1'b1 && n < 100) begin
         if (pstb_w[0] === 1'b0) low++;
         @(negedge clk);
         n++;
      end
      chk("t1_latency",   32'(n), 32'd17);
      chk("t1_pstb_low",  32'(low), 32'd4);
      chk("t1_result",    32'(result_w[0]), 32'd8);
      chk("t1_bubble",    32'(bubble_w[0]), 32'd0);
      for (int k = 0; k < 10; k++) begin
         chk("bp_valid",  32'(valid_w[0]), 32'd1);
         chk("bp_result", 32'(result_w[0]), 32'd8);
         start_v[0] = (k == 3);
         @(negedge clk);
      end
      ready_v[0] = 1'b1;
      @(negedge clk);
      ready_v[0] = 1'b0;
      chk("bp_exit_busy",  32'(busy_w[0]),  32'd0);
      chk("bp_exit_valid", 32'(valid_w[0]), 32'd0);
      repeat (5) @(negedge clk);
      chk("bp_no_queue", 32'(busy_w[0]), 32'd0);

      // Bubble code, then clean code with ignored start pulses during PRESET and SETTLE.
      therm_v[0] = 32'h0000_00F7;
      ready_v[0] = 1'b1;
      pulse_start(0);
      wait_valid(0, n);
      chk("bub_result", 32'(result_w[0]), 32'd7);
      chk("bub_flag",   32'(bubble_w[0]), 32'd1);
      @(negedge clk);
      chk("bub_valid_1cyc", 32'(valid_w[0]), 32'd0);
      chk("bub_sticky",     32'(bubble_w[0]), 32'd1);
      therm_v[0] = 32'h0000_00FF;
      pulse_start(0);
      chk("bub_cleared", 32'(bubble_w[0]), 32'd0);
      nv = 0;
      for (int i = 1; i < 60; i++) begin
         start_v[0] = (i == 1) || (i == 8);
         if (valid_w[0] === 1'b1) nv++;
         @(negedge clk);
      end
      start_v[0] = 1'b0;
      chk("one_result", 32'(nv), 32'd1);
      chk("idle_after", 32'(busy_w[0]), 32'd0);
      ready_v[0] = 1'b0;

      // Four averaged measurements with phase reversal.
      pr_en_v[1] = 1'b1;
      pulse_start(1);
      nl = 0; npr = 0; n = 0;
      while (valid_w[1] !== 1'b1 && n < 200) begin
         if (launch_w[1] === 1'b1 && nl < 4) begin
            therm_v[1] = tbl[nl];
            nl++;
         end
         if (prc_w[1] === 1'b1) npr++;
         @(negedge clk);
         n++;
      end
      chk("avg_launches", 32'(nl), 32'd4);
      chk("avg_prc_pulses", 32'(npr), 32'd4);
      chk("avg_result", 32'(result_w[1]), 32'd6);
      chk("avg_bubble", 32'(bubble_w[1]), 32'd0);
      ready_v[1] = 1'b1;
      @(negedge clk);
      ready_v[1] = 1'b0;
      chk("avg_exit_valid", 32'(valid_w[1]), 32'd0);

      // Reset during SETTLE of the second measurement, then a clean acquisition.
      therm_v[1] = 32'h0000_FFFF;
      pulse_start(1);
      nl = 0; n = 0;
      while (nl < 2 && n < 100) begin
         if (launch_w[1] === 1'b1) nl++;
         if (nl < 2) @(negedge clk);
         n++;
      end
      chk("rst_second_launch", 32'(nl), 32'd2);
      repeat (3) @(negedge clk);
      rst_v[1] = 1'b1;
      @(negedge clk);
      rst_v[1] = 1'b0;
      chk("midrst_pstb",   32'(pstb_w[1]),   32'd1);
      chk("midrst_launch", 32'(launch_w[1]), 32'd0);
      chk("midrst_busy",   32'(busy_w[1]),   32'd0);
      chk("midrst_valid",  32'(valid_w[1]),  32'd0);
      pr_en_v[1] = 1'b0;
      therm_v[1] = 32'h0000_000F;
      pulse_start(1);
      wait_valid(1, n);
      chk("postrst_result", 32'(result_w[1]), 32'd4);
      ready_v[1] = 1'b1;
      @(negedge clk);
      ready_v[1] = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
Name: tdc_meas_ctrl

Overview:
Sequencer for the phase-reversing TDC delay-line array (N_STAGES delay units with preset, phase-reverse clock and flip-flop capture). It runs the sequence preset -> launch -> settle -> capture -> phase-reverse for each measurement. It decodes the captured thermometer code to a binary stage count and averages 2^AVG_LOG2 measurements. Results go to the digital back-end through a valid/ready handshake.

Parameters:
N_STAGES, 32, number of delay units / thermometer bits
CW, 6, count width; must be >= clog2(N_STAGES+1)
PRESET_CYC, 4, cycles pstb held low in PRESET (>=1)
SETTLE_CYC, 8, cycles between launch and capture (>=1)
AVG_LOG2, 2, log2 of measurements averaged per result (0..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a result acquisition; sampled in IDLE only
pr_en  in  1  enable phase-reverse pulse and polarity toggling
therm_in  in  N_STAGES  ff_out bits from the delay units, already synchronised
pstb  out  1  active-low preset to all delay units
launch  out  1  start edge into the delay-line input
phase_rev_clk  out  1  phase-reverse clock to all delay units
result  out  CW  averaged stage count
result_valid  out  1  result is valid
result_ready  in  1  consumer accepts result
bubble_err  out  1  sticky; at least one non-monotonic code in the current result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, pstb=1, launch=0, phase_rev_clk=0, result=0, result_valid=0, bubble_err=0, busy=0, pol=1, meas_cnt=0, acc=0.
- State sequence: IDLE -> PRESET -> LAUNCH -> SETTLE -> CAPTURE -> PHREV -> ACCUM -> (LAUNCH | DONE) -> IDLE.
- IDLE: if start=1, go to PRESET. Clear acc, meas_cnt and bubble_err on that transition.
- PRESET: pstb=0 for exactly PRESET_CYC cycles. This initialises phase_reverse=1 in the units and sets pol=1.
- LAUNCH: one cycle, launch=1. launch returns to 0 on the next cycle.
- SETTLE: wait exactly SETTLE_CYC cycles.
- CAPTURE: one cycle. code = therm_in XOR {N_STAGES{~pol}}.
  - count = number of ones in code (0..N_STAGES).
  - Bubble: any bit i=1 with bit i-1=0 (i>=1). On a bubble, set bubble_err=1; count is still used.
- PHREV:
  - If pr_en=1: phase_rev_clk=1 for one cycle, then 0. pol toggles on the cycle phase_rev_clk falls.
  - If pr_en=0: one idle cycle, phase_rev_clk stays 0, pol unchanged.
- ACCUM: acc += count; acc is CW+AVG_LOG2 bits and cannot overflow. meas_cnt += 1.
  - If meas_cnt reaches 2^AVG_LOG2, go to DONE.
  - Otherwise go to LAUNCH directly, with no re-preset.
- Measurement cost: 1+SETTLE_CYC+1+1+1 cycles each. Preset cost: PRESET_CYC+... once per result.
- DONE: result = acc >> AVG_LOG2 (truncate) and result_valid=1, both registered on entry.
  - Hold result and result_valid stable until result_ready=1 is sampled. Leave on that cycle and drop result_valid the next cycle.
  - If result_ready=1 on the first DONE cycle, result_valid is high for exactly one cycle.
- start outside IDLE is ignored, with no queueing. start held high at DONE exit begins a new acquisition on the next IDLE cycle.
- bubble_err is valid alongside result and cleared only at the next IDLE->PRESET transition or by rst.
- rst mid-operation: state, outputs and pol return to reset values in the same cycle the reset is sampled. A partial accumulation is discarded and no result_valid is issued.
- pstb, launch and phase_rev_clk are registered outputs and glitch-free.

Test Plan:
- AVG_LOG2=0, pr_en=0, therm_in=32'h0000_00FF, start pulse -> after PRESET_CYC+1+SETTLE_CYC+4 cycles: result_valid=1, result=8, bubble_err=0; pstb low exactly 4 cycles.
- AVG_LOG2=2, pr_en=1:
  - therm_in=0x000000FF for measurement 1 (pol=1).
  - therm_in=~0x0000FFFF for measurement 2 (pol=0, count=16).
  - therm_in=0x0 for measurement 3 (pol=1).
  - therm_in=0xFFFFFFFF for measurement 4 (pol=0).
  - Required: phase_rev_clk pulses 4 times; result=(8+16+0+0)>>2=6.
- Bubble: therm_in=32'h0000_00F7, AVG_LOG2=0 -> count=7, bubble_err=1. Next start with clean code -> bubble_err cleared on PRESET entry.
- Backpressure: result_ready=0 for 10 cycles in DONE -> result_valid and result stable all 10 cycles. Exit on the cycle ready=1; busy=0 the following cycle.
- Reset: rst asserted during SETTLE of measurement 2 -> next cycle pstb=1, launch=0, busy=0, result_valid=0. A new start yields a clean result with no carry-over of acc.
- start pulses during PRESET/SETTLE/DONE are ignored: exactly one result per accepted start.
